// File: rtl/frame_streamer_if.sv
// Streaming pixel-source bus: frame control, frame-memory read port and pipeline beat outputs.
// master = the streamer; slave = the consumer/memory side.
interface frame_streamer_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int PIXEL_SIZE = 24
);
    logic                  start;
    logic                  stall;
    logic                  mem_rd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [PIXEL_SIZE-1:0] mem_data;
    logic                  en;
    logic [15:0]           x;
    logic [15:0]           y;
    logic [PIXEL_SIZE-1:0] data;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, stall, mem_data,
        output mem_rd, mem_addr, en, x, y, data, busy, done
    );

    modport slave (
        output start, stall, mem_data,
        input  mem_rd, mem_addr, en, x, y, data, busy, done
    );
endinterface

// File: rtl/frame_streamer.sv
// Raster frame reader + zero flush beats; beat appears 2 cycles after its issue slot.
// stall blocks new slots from the next cycle on; slots already issued always complete.
module frame_streamer #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int ADDR_WIDTH   = 19,
    parameter int PIXEL_SIZE   = 24,
    parameter int FLUSH_PIXELS = FRAME_WIDTH + 4
) (
    input  logic              clk,
    input  logic              reset,
    frame_streamer_if.master  bus
);
    typedef enum logic [2:0] {IDLE, STREAM, FLUSH, DRAIN, DONE} state_t;

    localparam int TOTAL = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int FW    = (FLUSH_PIXELS > 1) ? $clog2(FLUSH_PIXELS) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(TOTAL - 1);
    localparam logic [FW-1:0]         LAST_FLUSH = FW'((FLUSH_PIXELS > 0) ? FLUSH_PIXELS - 1 : 0);
    localparam logic [15:0]           LAST_X     = 16'(FRAME_WIDTH - 1);

    state_t      state;
    logic        slot;      // an issue slot occurs in the current cycle
    logic [FW-1:0] fl_cnt;
    logic [15:0] x_cnt;
    logic [15:0] y_cnt;
    logic        p1_vld;
    logic        p1_flush;
    logic [15:0] p1_x;
    logic [15:0] p1_y;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            slot         <= 1'b0;
            fl_cnt       <= '0;
            x_cnt        <= '0;
            y_cnt        <= '0;
            p1_vld       <= 1'b0;
            p1_flush     <= 1'b0;
            p1_x         <= '0;
            p1_y         <= '0;
            bus.mem_rd   <= 1'b0;
            bus.mem_addr <= '0;
            bus.en       <= 1'b0;
            bus.x        <= '0;
            bus.y        <= '0;
            bus.data     <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            // Stage 1 carries the slot's coordinates while the memory read is in flight.
            p1_vld   <= slot;
            p1_flush <= (state == FLUSH);
            p1_x     <= x_cnt;
            p1_y     <= y_cnt;

            bus.en <= p1_vld;
            if (p1_vld) begin
                bus.x    <= p1_x;
                bus.y    <= p1_y;
                bus.data <= p1_flush ? PIXEL_SIZE'(0) : bus.mem_data;
            end

            if (slot) begin
                if (x_cnt == LAST_X) begin
                    x_cnt <= '0;
                    y_cnt <= y_cnt + 16'd1;
                end else begin
                    x_cnt <= x_cnt + 16'd1;
                end
            end

            case (state)
                // DONE with start still high chains straight into the next frame.
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        state        <= STREAM;
                        bus.busy     <= 1'b1;
                        slot         <= !bus.stall;
                        bus.mem_rd   <= !bus.stall;
                        bus.mem_addr <= '0;
                        fl_cnt       <= '0;
                        x_cnt        <= '0;
                        y_cnt        <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                STREAM: begin
                    if (slot && bus.mem_addr == LAST_ADDR) begin
                        bus.mem_rd <= 1'b0;
                        if (FLUSH_PIXELS == 0) begin
                            state <= DRAIN;
                            slot  <= 1'b0;
                        end else begin
                            state <= FLUSH;
                            slot  <= !bus.stall;
                        end
                    end else begin
                        if (slot)
                            bus.mem_addr <= bus.mem_addr + 1'b1;
                        slot       <= !bus.stall;
                        bus.mem_rd <= !bus.stall;
                    end
                end
                FLUSH: begin
                    if (slot && fl_cnt == LAST_FLUSH) begin
                        state <= DRAIN;
                        slot  <= 1'b0;
                    end else begin
                        if (slot)
                            fl_cnt <= fl_cnt + 1'b1;
                        slot <= !bus.stall;
                    end
                end
                DRAIN: begin
                    // The final beat sits in the output register now; done follows it.
                    if (!p1_vld) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_streamer.sv
// Scoreboard bench: stimulus queues expected reads/beats/done, negedge monitors pop and compare.
module tb_frame_streamer;
    typedef struct { int cyc; int x; int y; int d; } beat_t;
    typedef struct { int cyc; int addr; } rd_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    rd_t   rd_a[$];
    beat_t bt_a[$];
    int    dn_a[$];
    beat_t bt_b[$];
    int    done_b = 0;
    bit    prev_done_b = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    frame_streamer_if #(.ADDR_WIDTH(4), .PIXEL_SIZE(24)) ia ();
    frame_streamer_if #(.ADDR_WIDTH(5), .PIXEL_SIZE(24)) ib ();

    frame_streamer #(.FRAME_WIDTH(4), .FRAME_HEIGHT(3), .ADDR_WIDTH(4),
                     .PIXEL_SIZE(24), .FLUSH_PIXELS(2))
        dut_a (.clk(clk), .reset(reset), .bus(ia));

    frame_streamer #(.FRAME_WIDTH(8), .FRAME_HEIGHT(4), .ADDR_WIDTH(5),
                     .PIXEL_SIZE(24), .FLUSH_PIXELS(12))
        dut_b (.clk(clk), .reset(reset), .bus(ib));

    // Frame memories: word i holds i + 0x100, one cycle read latency.
    always @(posedge clk) if (ia.mem_rd) ia.mem_data <= 24'(ia.mem_addr) + 24'h100;
    always @(posedge clk) if (ib.mem_rd) ib.mem_data <= 24'(ib.mem_addr) + 24'h100;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected traffic for a W=4,H=3,FLUSH=2 frame started at cycle t0; a 3-cycle gap after slot 3 if gap=3.
    task automatic push_a(input int t0, input int gap, input int nrd, input int nbt, input bit dn);
        int sc;
        for (int s = 0; s < 14; s++) begin
            sc = t0 + 1 + s + ((s >= 4) ? gap : 0);
            if (s < nrd) rd_a.push_back('{sc, s});
            if (s < nbt) bt_a.push_back('{sc + 2, s % 4, s / 4, (s < 12) ? s + 256 : 0});
            if (dn && s == 13) dn_a.push_back(sc + 3);
        end
    endtask

    task automatic wait_a(input int budget);
        int n = 0;
        while ((rd_a.size() + bt_a.size() + dn_a.size()) != 0 && n < budget) begin
            step();
            n++;
        end
        chk("a_drain", rd_a.size() + bt_a.size() + dn_a.size(), 0);
        step();
        step();
    endtask

    always @(negedge clk) begin
        rd_t   r;
        beat_t b;
        if (ia.mem_rd) begin
            if (rd_a.size() == 0) chk("rd_a_pending", rd_a.size(), 1);
            else begin
                r = rd_a.pop_front();
                chk("rd_a_cycle", cyc, r.cyc);
                chk("rd_a_addr", ia.mem_addr, r.addr);
            end
        end
        if (ia.en) begin
            if (bt_a.size() == 0) chk("beat_a_pending", bt_a.size(), 1);
            else begin
                b = bt_a.pop_front();
                chk("beat_a_cycle", cyc, b.cyc);
                chk("beat_a_x", ia.x, b.x);
                chk("beat_a_y", ia.y, b.y);
                chk("beat_a_data", ia.data, b.d);
            end
        end
        if (ia.done) begin
            if (dn_a.size() == 0) chk("done_a_pending", dn_a.size(), 1);
            else chk("done_a_cycle", cyc, dn_a.pop_front());
            chk("busy_a_at_done", ia.busy, 0);
        end
    end

    always @(negedge clk) begin
        beat_t b;
        if (ib.en) begin
            if (bt_b.size() == 0) chk("beat_b_pending", bt_b.size(), 1);
            else begin
                b = bt_b.pop_front();
                chk("beat_b_x", ib.x, b.x);
                chk("beat_b_y", ib.y, b.y);
                chk("beat_b_data", ib.data, b.d);
            end
        end
        if (ib.done) begin
            chk("done_b_pulse", prev_done_b, 0);
            chk("busy_b_at_done", ib.busy, 0);
            done_b++;
        end
        prev_done_b = ib.done;
    end

    initial begin
        int t0;
        int n;
        ia.start = 1'b1;
        ia.stall = 1'b0;
        ib.start = 1'b0;
        ib.stall = 1'b0;

        // Reset held two cycles with start high: everything quiet.
        step();
        chk("rst_en", ia.en, 0);
        chk("rst_x", ia.x, 0);
        chk("rst_y", ia.y, 0);
        chk("rst_data", ia.data, 0);
        chk("rst_mem_rd", ia.mem_rd, 0);
        chk("rst_mem_addr", ia.mem_addr, 0);
        chk("rst_busy", ia.busy, 0);
        chk("rst_done", ia.done, 0);
        step();
        reset = 1'b0;
        t0 = cyc;
        push_a(t0, 0, 12, 14, 1'b1);
        step();
        ia.start = 1'b0;
        chk("busy_first_cycle", ia.busy, 1);
        wait_a(60);

        // Stall sampled high at edges ending cycles 4..6.
        t0 = cyc;
        ia.start = 1'b1;
        push_a(t0, 3, 12, 14, 1'b1);
        for (int c = 1; c <= 7; c++) begin
            step();
            ia.start = 1'b0;
            ia.stall = (c >= 4 && c <= 6);
        end
        wait_a(60);

        // Extra start pulses mid-frame are ignored; start held through DONE chains a second frame.
        t0 = cyc;
        ia.start = 1'b1;
        push_a(t0, 0, 12, 14, 1'b1);
        push_a(t0 + 17, 0, 12, 14, 1'b1);
        for (int c = 1; c <= 18; c++) begin
            step();
            ia.start = (c == 5 || c == 10 || (c >= 15 && c <= 17));
        end
        wait_a(80);

        // Reset in cycle 8 aborts the frame; a new start begins from address 0.
        t0 = cyc;
        ia.start = 1'b1;
        push_a(t0, 0, 8, 6, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            step();
            ia.start = 1'b0;
            reset = (c == 8);
        end
        step();
        reset = 1'b0;
        chk("midrst_en", ia.en, 0);
        chk("midrst_busy", ia.busy, 0);
        chk("midrst_mem_rd", ia.mem_rd, 0);
        chk("midrst_leftover", rd_a.size() + bt_a.size(), 0);
        step();
        t0 = cyc;
        ia.start = 1'b1;
        push_a(t0, 0, 12, 14, 1'b1);
        step();
        ia.start = 1'b0;
        wait_a(60);

        // Back-to-back W=8,H=4 frames with ~30% random stall.
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < 44; k++)
                bt_b.push_back('{-1, k % 8, k / 8, (k < 32) ? k + 256 : 0});
        ib.start = 1'b1;
        n = 0;
        while (done_b < 3 && n < 2000) begin
            step();
            n++;
            ib.stall = ($urandom_range(0, 9) < 3);
            if (done_b >= 2) ib.start = 1'b0;
        end
        ib.stall = 1'b0;
        step();
        step();
        chk("b_frames", done_b, 3);
        chk("b_leftover", bt_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
